// File: rtl/gray_addr_seq.sv
// Address sequencer fed by an upstream Gray counter: decodes each code to a binary
// address, flags Gray steps that do not change exactly one bit, and ends at LAST_ADDR.
module gray_addr_seq #(
    parameter int             AW        = 16,
    parameter logic [AW-1:0]  LAST_ADDR = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          cnt_en,
    input  logic [AW-1:0] gray_in,
    output logic [AW-1:0] addr,
    output logic          addr_vld,
    output logic          done,
    output logic          seq_err,
    output logic [7:0]    err_cnt
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] bin;
    logic [AW-1:0] prev_g;
    logic          first_sample;
    logic          step_ok;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PRIME;
            PRIME:   next_state = RUN;
            RUN:     if (bin == LAST_ADDR) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cnt_en = (state == PRIME) || (state == RUN);
        done   = (state == DONE);
    end

    // Prefix XOR from the MSB down turns the Gray code into binary.
    always_comb begin
        logic acc;
        bin = '0;
        acc = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
            acc    = acc ^ gray_in[i];
            bin[i] = acc;
        end
    end

    assign step_ok = ($countones(gray_in ^ prev_g) == 1);

    // The first RUN sample only seeds prev_g; every later one is step-checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= '0;
            addr_vld     <= 1'b0;
            seq_err      <= 1'b0;
            err_cnt      <= 8'd0;
            prev_g       <= '0;
            first_sample <= 1'b0;
        end else begin
            addr_vld <= (state == RUN);
            if ((state == IDLE) && start) begin
                seq_err <= 1'b0;
                err_cnt <= 8'd0;
            end
            if (state == PRIME) begin
                first_sample <= 1'b1;
            end
            if (state == RUN) begin
                addr         <= bin;
                prev_g       <= gray_in;
                first_sample <= 1'b0;
                if (!first_sample && !step_ok) begin
                    seq_err <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
